segment_sequencer: RTL and testbench

//  Parametrised successor to the single-shot double-buffered segment swap in the waveform top level.

---
 rtl/segseq_pkg.sv | 38 +++
 rtl/segment_queue.sv | 74 +++++++
 rtl/segment_sequencer.sv | 162 ++++++++++++++++
 tb/tb_segment_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/segseq_pkg.sv
// Shared definitions for the segment sequencer: FSM state encoding,
// segment word width and field offsets for packing a queued segment.
// Segment word layout, MSB to LSB: {amps, offsets, phasewords, duration}.
package segseq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  localparam int NCH_DEF = 64;
  localparam int AW_DEF  = 16;
  localparam int PW_DEF  = 16;
  localparam int DW_DEF  = 16;

  function automatic int segWidth(input int nch, input int aw, input int pw, input int dw);
    return nch * (2 * aw + pw) + dw;
  endfunction

  function automatic int durLsb();
    return 0;
  endfunction

  function automatic int phLsb(input int dw);
    return dw;
  endfunction

  function automatic int offLsb(input int nch, input int pw, input int dw);
    return dw + nch * pw;
  endfunction

  function automatic int ampLsb(input int nch, input int aw, input int pw, input int dw);
    return dw + nch * pw + nch * aw;
  endfunction

  localparam int SEG_W = segWidth(NCH_DEF, AW_DEF, PW_DEF, DW_DEF);

endpackage

// File: rtl/segment_queue.sv
// Circular buffer of DEPTH segment words. The caller qualifies push and
// pop; recirculation writes the current head back at the tail in the same
// cycle it is popped, so a looping sequence keeps its level constant.
module segment_queue
  import segseq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SW    = SEG_W,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [SW-1:0] wdata_i,
  input  logic          pop_i,
  input  logic          recirc_i,
  output logic [SW-1:0] head_o,
  output logic [LW-1:0] level_o
);

  logic [SW-1:0]   mem_q [DEPTH];
  logic [PTRW-1:0] rdPtr_q, rdPtr_d;
  logic [PTRW-1:0] wrPtr_q, wrPtr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            wrEn;
  logic [SW-1:0]   wrData;

  function automatic logic [PTRW-1:0] nextPtr(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_o  = mem_q[rdPtr_q];
  assign level_o = level_q;
  assign wrEn    = push_i | recirc_i;
  assign wrData  = recirc_i ? mem_q[rdPtr_q] : wdata_i;

  // Next pointer and occupancy values; flush empties the buffer outright.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    level_d = level_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      level_d = '0;
    end else begin
      if (pop_i)  rdPtr_d = nextPtr(rdPtr_q);
      if (wrEn)   wrPtr_d = nextPtr(wrPtr_q);
      if (wrEn && !pop_i)      level_d = level_q + 1'b1;
      else if (!wrEn && pop_i) level_d = level_q - 1'b1;
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      level_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      level_q <= level_d;
    end
  end

  // Segment storage; contents are only meaningful below the level count.
  always_ff @(posedge clk_i) begin
    if (wrEn && !flush_i) mem_q[wrPtr_q] <= wrData;
  end

endmodule

// File: rtl/segment_sequencer.sv
// Segment sequencer: plays queued oscillator-bank segments back-to-back,
// driving the active amplitude/offset/phase buses for max(dur,1) cycles each.
// Optional feature macro SEGSEQ_LOOP_EN adds the loop_i port, which makes
// each popped segment recirculate to the queue tail so the sequence repeats.
module segment_sequencer
  import segseq_pkg::*;
#(
  parameter int NCH   = 64,
  parameter int AW    = 16,
  parameter int PW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH + 1),
  localparam int SW   = segWidth(NCH, AW, PW, DW)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              flush_i,
  input  logic              seg_we_i,
  input  logic [NCH*AW-1:0] seg_amps_i,
  input  logic [NCH*AW-1:0] seg_offsets_i,
  input  logic [NCH*PW-1:0] seg_phasewords_i,
  input  logic [DW-1:0]     seg_duration_i,
`ifdef SEGSEQ_LOOP_EN
  input  logic              loop_i,
`endif
  output logic              seg_ready_o,
  output logic [LW-1:0]     level_o,
  output logic [NCH*AW-1:0] act_amps_o,
  output logic [NCH*AW-1:0] act_offsets_o,
  output logic [NCH*PW-1:0] act_phasewords_o,
  output logic              act_valid_o,
  output logic              seg_start_o,
  output logic              seq_done_o,
  output logic [15:0]       seg_count_o
);

  localparam int AMP_LSB = ampLsb(NCH, AW, PW, DW);
  localparam int OFF_LSB = offLsb(NCH, PW, DW);
  localparam int PH_LSB  = phLsb(DW);
  localparam int DUR_LSB = durLsb();

  seq_state_e        state_q;
  logic [DW-1:0]     counter_q;
  logic [NCH*AW-1:0] actAmps_q;
  logic [NCH*AW-1:0] actOffsets_q;
  logic [NCH*PW-1:0] actPhase_q;
  logic              actValid_q;
  logic              segStart_q;
  logic              seqDone_q;
  logic [15:0]       segCount_q;

  logic [SW-1:0]     head;
  logic [SW-1:0]     pushWord;
  logic [DW-1:0]     headDur;
  logic [DW-1:0]     durLoad;
  logic              loopEn;
  logic              lastCycle;
  logic              startGo;
  logic              runPop;
  logic              pop;
  logic              recirc;
  logic              push;

`ifdef SEGSEQ_LOOP_EN
  assign loopEn = loop_i;
`else
  assign loopEn = 1'b0;
`endif

  assign pushWord  = {seg_amps_i, seg_offsets_i, seg_phasewords_i, seg_duration_i};
  assign headDur   = head[DUR_LSB +: DW];
  assign durLoad   = (headDur == '0) ? '0 : headDur - 1'b1;
  assign lastCycle = (state_q == ST_RUN) && (counter_q == '0);
  assign startGo   = (state_q == ST_IDLE) && start_i && (level_o != '0) && !stop_i && !flush_i;
  assign runPop    = lastCycle && (level_o != '0) && !stop_i && !flush_i;
  assign pop       = startGo | runPop;
  assign recirc    = pop & loopEn;
  assign seg_ready_o = (level_o < LW'(DEPTH)) && !recirc;
  assign push      = seg_we_i && seg_ready_o && !stop_i && !flush_i;

  segment_queue #(
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_queue (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .flush_i  (flush_i & ~stop_i),
    .push_i   (push),
    .wdata_i  (pushWord),
    .pop_i    (pop),
    .recirc_i (recirc),
    .head_o   (head),
    .level_o  (level_o)
  );

  // Playback FSM with the duration counter, active buses and status pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      counter_q    <= '0;
      actAmps_q    <= '0;
      actOffsets_q <= '0;
      actPhase_q   <= '0;
      actValid_q   <= 1'b0;
      segStart_q   <= 1'b0;
      seqDone_q    <= 1'b0;
      segCount_q   <= '0;
    end else begin
      segStart_q <= 1'b0;
      seqDone_q  <= 1'b0;
      if (stop_i) begin
        state_q    <= ST_IDLE;
        actValid_q <= 1'b0;
        seqDone_q  <= (state_q == ST_RUN);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (startGo) begin
              state_q      <= ST_RUN;
              counter_q    <= durLoad;
              actAmps_q    <= head[AMP_LSB +: NCH*AW];
              actOffsets_q <= head[OFF_LSB +: NCH*AW];
              actPhase_q   <= head[PH_LSB +: NCH*PW];
              actValid_q   <= 1'b1;
              segStart_q   <= 1'b1;
              segCount_q   <= 16'd1;
            end
          end
          ST_RUN: begin
            if (counter_q != '0) begin
              counter_q <= counter_q - 1'b1;
            end else if (runPop) begin
              counter_q    <= durLoad;
              actAmps_q    <= head[AMP_LSB +: NCH*AW];
              actOffsets_q <= head[OFF_LSB +: NCH*AW];
              actPhase_q   <= head[PH_LSB +: NCH*PW];
              segStart_q   <= 1'b1;
              segCount_q   <= segCount_q + 16'd1;
            end else begin
              state_q    <= ST_IDLE;
              actValid_q <= 1'b0;
              seqDone_q  <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign act_amps_o       = actAmps_q;
  assign act_offsets_o    = actOffsets_q;
  assign act_phasewords_o = actPhase_q;
  assign act_valid_o      = actValid_q;
  assign seg_start_o      = segStart_q;
  assign seq_done_o       = seqDone_q;
  assign seg_count_o      = segCount_q;

endmodule

// File: tb/tb_segment_sequencer.sv
// Directed testbench for segment_sequencer with a narrow configuration
// (2 channels, 8-bit fields). Segment id k carries amps 16'hA000+k,
// offsets 16'hB000+k, phase words 16'hC000+k. The loop scenario is built
// only when SEGSEQ_LOOP_EN is defined.
module tb_segment_sequencer;

  localparam int NCH   = 2;
  localparam int AW    = 8;
  localparam int PW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              stop;
  logic              flush;
  logic              segWe;
  logic [NCH*AW-1:0] segAmps;
  logic [NCH*AW-1:0] segOffsets;
  logic [NCH*PW-1:0] segPhase;
  logic [DW-1:0]     segDur;
`ifdef SEGSEQ_LOOP_EN
  logic              loop;
`endif
  logic              segReady;
  logic [LW-1:0]     level;
  logic [NCH*AW-1:0] actAmps;
  logic [NCH*AW-1:0] actOffsets;
  logic [NCH*PW-1:0] actPhase;
  logic              actValid;
  logic              segStart;
  logic              seqDone;
  logic [15:0]       segCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  segment_sequencer #(
    .NCH   (NCH),
    .AW    (AW),
    .PW    (PW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .start_i          (start),
    .stop_i           (stop),
    .flush_i          (flush),
    .seg_we_i         (segWe),
    .seg_amps_i       (segAmps),
    .seg_offsets_i    (segOffsets),
    .seg_phasewords_i (segPhase),
    .seg_duration_i   (segDur),
`ifdef SEGSEQ_LOOP_EN
    .loop_i           (loop),
`endif
    .seg_ready_o      (segReady),
    .level_o          (level),
    .act_amps_o       (actAmps),
    .act_offsets_o    (actOffsets),
    .act_phasewords_o (actPhase),
    .act_valid_o      (actValid),
    .seg_start_o      (segStart),
    .seq_done_o       (seqDone),
    .seg_count_o      (segCount)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Presents a segment on the write bus with the given write enable.
  task automatic applyStimulus(input int id, input int dur, input logic we);
    segWe      = we;
    segAmps    = 16'hA000 + 16'(id);
    segOffsets = 16'hB000 + 16'(id);
    segPhase   = 16'hC000 + 16'(id);
    segDur     = 8'(dur);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    flush = 1'b0;
`ifdef SEGSEQ_LOOP_EN
    loop  = 1'b0;
`endif
    applyStimulus(0, 0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_valid", 32'(actValid), 0);
    checkOutput("rst_amps", 32'(actAmps), 0);
    checkOutput("rst_count", 32'(segCount), 0);
    checkOutput("rst_ready", 32'(segReady), 1);

    // Three segments of duration 5, 1, 0 played back-to-back
    applyStimulus(1, 5, 1'b1); tick();
    applyStimulus(2, 1, 1'b1); tick();
    applyStimulus(3, 0, 1'b1); tick();
    segWe = 1'b0;
    checkOutput("t1_level3", 32'(level), 3);
    start = 1'b1; tick(); start = 1'b0;
    checkOutput("t1_c1_valid", 32'(actValid), 1);
    checkOutput("t1_c1_start", 32'(segStart), 1);
    checkOutput("t1_c1_amps", 32'(actAmps), 32'hA001);
    checkOutput("t1_c1_offs", 32'(actOffsets), 32'hB001);
    checkOutput("t1_c1_phase", 32'(actPhase), 32'hC001);
    checkOutput("t1_c1_count", 32'(segCount), 1);
    checkOutput("t1_c1_level", 32'(level), 2);
    for (int c = 2; c <= 8; c++) begin
      tick();
      checkOutput($sformatf("t1_c%0d_valid", c), 32'(actValid), (c <= 7) ? 1 : 0);
      checkOutput($sformatf("t1_c%0d_start", c), 32'(segStart), (c == 6 || c == 7) ? 1 : 0);
      checkOutput($sformatf("t1_c%0d_done", c), 32'(seqDone), (c == 8) ? 1 : 0);
      checkOutput($sformatf("t1_c%0d_amps", c), 32'(actAmps),
                  (c <= 5) ? 32'hA001 : (c == 6) ? 32'hA002 : 32'hA003);
    end
    checkOutput("t1_count3", 32'(segCount), 3);
    checkOutput("t1_level0", 32'(level), 0);

    // Overfill while idle: fifth push is dropped
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4 + i, 2, 1'b1);
      checkOutput($sformatf("t2_ready%0d", i), 32'(segReady), (i < 4) ? 1 : 0);
      tick();
    end
    segWe = 1'b0;
    checkOutput("t2_level", 32'(level), 4);
    checkOutput("t2_ready", 32'(segReady), 0);

    // Flush during RUN: current segment (id 4, dur 2) still completes
    start = 1'b1; tick(); start = 1'b0;
    checkOutput("t5_amps", 32'(actAmps), 32'hA004);
    checkOutput("t5_level3", 32'(level), 3);
    flush = 1'b1; tick(); flush = 1'b0;
    checkOutput("t5_level0", 32'(level), 0);
    checkOutput("t5_valid", 32'(actValid), 1);
    tick();
    checkOutput("t5_end_valid", 32'(actValid), 0);
    checkOutput("t5_end_done", 32'(seqDone), 1);
    checkOutput("t5_end_amps", 32'(actAmps), 32'hA004);

    // Underrun: push on the final cycle does not extend playback
    applyStimulus(9, 3, 1'b1); tick(); segWe = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checkOutput("t3_amps", 32'(actAmps), 32'hA009);
    checkOutput("t3_level0", 32'(level), 0);
    tick();
    tick();
    applyStimulus(10, 3, 1'b1);
    checkOutput("t3_ready", 32'(segReady), 1);
    tick();
    segWe = 1'b0;
    checkOutput("t3_valid", 32'(actValid), 0);
    checkOutput("t3_done", 32'(seqDone), 1);
    checkOutput("t3_level1", 32'(level), 1);
    checkOutput("t3_count", 32'(segCount), 1);

    // Stop mid-segment with two queued segments
    applyStimulus(11, 4, 1'b1); tick();
    applyStimulus(12, 4, 1'b1); tick();
    segWe = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checkOutput("t4_amps", 32'(actAmps), 32'hA00A);
    checkOutput("t4_level2", 32'(level), 2);
    stop = 1'b1; tick(); stop = 1'b0;
    checkOutput("t4_valid", 32'(actValid), 0);
    checkOutput("t4_done", 32'(seqDone), 1);
    checkOutput("t4_level", 32'(level), 2);
    tick();
    checkOutput("t4_done_clr", 32'(seqDone), 0);
    stop = 1'b1; tick(); stop = 1'b0;
    checkOutput("t4_idle_stop_done", 32'(seqDone), 0);
    checkOutput("t4_idle_stop_level", 32'(level), 2);

    // Flush while idle, then start on an empty queue is ignored
    flush = 1'b1; tick(); flush = 1'b0;
    checkOutput("flush_level", 32'(level), 0);
    start = 1'b1; tick(); start = 1'b0;
    checkOutput("empty_start_valid", 32'(actValid), 0);
    checkOutput("empty_start_pulse", 32'(segStart), 0);

`ifdef SEGSEQ_LOOP_EN
    // Loop mode: two segments of duration 3 alternate indefinitely
    applyStimulus(20, 3, 1'b1); tick();
    applyStimulus(21, 3, 1'b1); tick();
    segWe = 1'b0;
    loop  = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      checkOutput($sformatf("t6_c%0d_amps", c), 32'(actAmps),
                  ((((c - 1) / 3) % 2) == 0) ? 32'hA014 : 32'hA015);
      checkOutput($sformatf("t6_c%0d_valid", c), 32'(actValid), 1);
      checkOutput($sformatf("t6_c%0d_start", c), 32'(segStart), (((c - 1) % 3) == 0) ? 1 : 0);
      checkOutput($sformatf("t6_c%0d_count", c), 32'(segCount), 32'((c - 1) / 3 + 1));
      checkOutput($sformatf("t6_c%0d_level", c), 32'(level), 2);
      checkOutput($sformatf("t6_c%0d_ready", c), 32'(segReady), ((c % 3) == 0) ? 0 : 1);
      if (c < 12) tick();
    end
    loop = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    checkOutput("t6_stop_done", 32'(seqDone), 1);
    checkOutput("t6_stop_valid", 32'(actValid), 0);
    checkOutput("t6_stop_level", 32'(level), 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
